// File: rtl/i_ap_accum_ctrl_if.sv
// i_ap_accum_ctrl_if: control, operand-stream and result-stream signals of the saturating accumulator.
interface i_ap_accum_ctrl_if #(
    parameter int bitlength = 16,
    parameter int cntw = 8
);
    logic start;
    logic [cntw-1:0] len;
    logic busy;
    logic in_valid;
    logic signed [bitlength-1:0] in_data;
    logic in_ready;
    logic out_valid;
    logic signed [bitlength-1:0] out_data;
    logic out_sat;
    logic out_ready;
    modport master (
        output start, len, in_valid, in_data, out_ready,
        input busy, in_ready, out_valid, out_data, out_sat
    );
    modport slave (
        input start, len, in_valid, in_data, out_ready,
        output busy, in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/i_ap_accum_ctrl.sv
// i_ap_accum_ctrl: accumulates len signed beats with per-step saturation and presents one result.
module i_ap_accum_ctrl #(
    parameter int bitlength = 16,
    parameter int cntw = 8,
    parameter logic signed [bitlength-1:0] Inf = 16'sb0111_1111_1111_1111
) (
    input logic clk,
    input logic rst_n,
    i_ap_accum_ctrl_if.slave io
);
    typedef enum logic [1:0] {IDLE, ACCUM, OUT} state_t;
    state_t state_q, state_d;
    logic signed [bitlength-1:0] acc_q, acc_d, tmp;
    logic sat_q, sat_d, pos_o, neg_o;
    logic [cntw-1:0] cnt_q, cnt_d;
    always_comb begin
        tmp = acc_q + io.in_data;
        pos_o = !acc_q[bitlength-1] && !io.in_data[bitlength-1] && tmp[bitlength-1];
        neg_o = acc_q[bitlength-1] && io.in_data[bitlength-1] && !tmp[bitlength-1];
        state_d = state_q;
        acc_d = acc_q;
        sat_d = sat_q;
        cnt_d = cnt_q;
        unique case (state_q)
            IDLE: if (io.start) begin
                acc_d = '0;
                sat_d = 1'b0;
                cnt_d = io.len;
                state_d = (io.len == '0) ? OUT : ACCUM;
            end
            ACCUM: if (io.in_valid) begin
                acc_d = pos_o ? Inf : neg_o ? -Inf : tmp;
                sat_d = sat_q | pos_o | neg_o;
                cnt_d = cnt_q - cntw'(1);
                state_d = (cnt_q == cntw'(1)) ? OUT : ACCUM;
            end
            OUT: state_d = io.out_ready ? IDLE : OUT;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q <= '0;
            sat_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q <= acc_d;
            sat_q <= sat_d;
            cnt_q <= cnt_d;
        end
    end
    assign io.busy = state_q != IDLE;
    assign io.in_ready = state_q == ACCUM;
    assign io.out_valid = state_q == OUT;
    assign io.out_data = acc_q;
    assign io.out_sat = sat_q;
endmodule

// File: tb/tb_i_ap_accum_ctrl.sv
// tb_i_ap_accum_ctrl: directed vectors with a result scoreboard popped by an independent monitor.
module tb_i_ap_accum_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [16:0] exp_q[$];
    i_ap_accum_ctrl_if #(.bitlength(16), .cntw(8)) io ();
    i_ap_accum_ctrl dut (.clk(clk), .rst_n(rst_n), .io(io));
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic start_op(input logic [7:0] l, input logic push, input logic [15:0] d, input logic s);
        if (push) exp_q.push_back({s, d});
        io.start = 1'b1;
        io.len = l;
        @(posedge clk);
        #1 io.start = 1'b0;
        chk("busy_after_start", {31'd0, io.busy}, 32'd1);
    endtask
    task automatic beat(input logic [15:0] d, input int gap);
        int k;
        io.in_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1 io.in_valid = 1'b1;
        io.in_data = d;
        k = 0;
        while (!io.in_ready && k < 20) begin
            @(posedge clk);
            #1 k++;
        end
        if (k == 20) chk("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 io.in_valid = 1'b0;
    endtask
    task automatic finish_out(input string name);
        chk(name, {31'd0, io.out_valid}, 32'd1);
        @(posedge clk);
        #1 chk("idle_after_out", {31'd0, io.busy}, 32'd0);
    endtask
    initial forever begin
        @(negedge clk);
        if (rst_n && io.out_valid && io.out_ready) begin
            if (exp_q.size() == 0) chk("unexpected_result", 32'd1, 32'd0);
            else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                chk("out_data", {16'd0, io.out_data}, {16'd0, e[15:0]});
                chk("out_sat", {31'd0, io.out_sat}, {31'd0, e[16]});
            end
        end
    end
    initial begin
        io.start = 1'b0;
        io.len = '0;
        io.in_valid = 1'b0;
        io.in_data = '0;
        io.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, io.busy}, 32'd0);
        chk("rst_in_ready", {31'd0, io.in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, io.out_valid}, 32'd0);
        chk("rst_out_data", {16'd0, io.out_data}, 32'd0);
        chk("rst_out_sat", {31'd0, io.out_sat}, 32'd0);
        rst_n = 1'b1;
        start_op(8'd3, 1'b1, 16'd250, 1'b0);
        beat(16'd100, 0);
        beat(16'd200, 2);
        beat(-16'sd50, 1);
        finish_out("valid_after_last_beat");
        start_op(8'd2, 1'b1, 16'h7fff, 1'b1);
        beat(16'd30000, 0);
        beat(16'd10000, 0);
        finish_out("valid_pos_sat");
        start_op(8'd3, 1'b1, 16'd32762, 1'b1);
        beat(16'd30000, 0);
        beat(16'd10000, 1);
        beat(-16'sd5, 0);
        finish_out("valid_pos_sat_recover");
        start_op(8'd2, 1'b1, 16'h8001, 1'b1);
        beat(-16'sd30000, 0);
        beat(-16'sd10000, 0);
        finish_out("valid_neg_sat");
        start_op(8'd2, 1'b1, 16'h8000, 1'b0);
        beat(-16'sd32767, 0);
        beat(-16'sd1, 0);
        finish_out("valid_min_exact");
        start_op(8'd0, 1'b1, 16'd0, 1'b0);
        chk("len0_in_ready", {31'd0, io.in_ready}, 32'd0);
        finish_out("valid_len0");
        chk("len0_in_ready_after", {31'd0, io.in_ready}, 32'd0);
        io.out_ready = 1'b0;
        start_op(8'd1, 1'b1, 16'd5, 1'b0);
        beat(16'd5, 0);
        for (int i = 0; i < 5; i++) begin
            io.start = 1'b1;
            io.len = 8'd3;
            @(posedge clk);
            #1 chk("hold_valid", {31'd0, io.out_valid}, 32'd1);
            chk("hold_data", {16'd0, io.out_data}, 32'd5);
            chk("hold_sat", {31'd0, io.out_sat}, 32'd0);
        end
        io.start = 1'b0;
        io.out_ready = 1'b1;
        @(posedge clk);
        #1 chk("idle_after_ready", {31'd0, io.busy}, 32'd0);
        start_op(8'd4, 1'b0, 16'd0, 1'b0);
        beat(16'd1, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", {31'd0, io.busy}, 32'd0);
        chk("arst_in_ready", {31'd0, io.in_ready}, 32'd0);
        chk("arst_out_valid", {31'd0, io.out_valid}, 32'd0);
        chk("arst_out_data", {16'd0, io.out_data}, 32'd0);
        chk("arst_out_sat", {31'd0, io.out_sat}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        start_op(8'd1, 1'b1, 16'd7, 1'b0);
        beat(16'd7, 0);
        finish_out("valid_after_reset");
        repeat (3) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
